mlp_fsm: RTL and testbench

- Control FSM for a small fixed-point MLP accelerator. Sequences the weight SRAM (W) and a ping-pong activation SRAM (X, two banks) through an init/load phase and a layer-by-layer compute phase.
- Drives the datapath strobes for MAC accumulate-store and activation write-back. Contains no datapath.

---
 rtl/mlp_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_mlp_fsm.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mlp_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mlp_fsm
// Brief    : Control FSM for a small fixed-point MLP accelerator. It sequences
//            the weight load, the input load and layer-by-layer compute.
// Revision : 1.0 - initial release
// ============================================================================
module mlp_fsm #(
  parameter int N_LAYERS = 2,
  parameter int N_IN     = 32,
  parameter int N_OUT    = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_valid_i,
  output logic        init_ready_o,
  input  logic        start_valid_i,
  output logic        start_ready_o,
  output logic        result_valid_o,
  output logic        w_ren_o,
  output logic        w_wen_o,
  output logic [10:0] w_addr_o,
  output logic        x_ren_o,
  output logic        x_wen_o,
  output logic        x_sel_o,
  output logic [7:0]  x_addr_o,
  output logic        partial_sum_store_o,
  output logic        x_sram_write_back_o
);

  localparam int c_LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  localparam logic [10:0]     c_W_LAST     = 11'(N_LAYERS * N_IN * N_OUT - 1);
  localparam logic [7:0]      c_IN_LAST    = 8'(N_IN - 1);
  localparam logic [7:0]      c_OUT_LAST   = 8'(N_OUT - 1);
  localparam logic [c_LW-1:0] c_LAYER_LAST = c_LW'(N_LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_X = 3'd2,
    S_READ   = 3'd3,
    S_STORE  = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t          r_state;
  logic            r_init_done;
  logic [c_LW-1:0] r_layer;
  logic [7:0]      r_neuron;
  logic [7:0]      r_idx;
  logic [10:0]     r_wptr;

  logic            r_init_ready;
  logic            r_start_ready;
  logic            r_result_valid;
  logic            r_w_ren;
  logic            r_w_wen;
  logic [10:0]     r_w_addr;
  logic            r_x_ren;
  logic            r_x_wen;
  logic            r_x_sel;
  logic [7:0]      r_x_addr;
  logic            r_ps_store;
  logic            r_x_wb;

  // Outputs are registered: each transition loads the values the next state
  // presents, so no input valid ever reaches an output combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= S_IDLE;
      r_init_done    <= 1'b0;
      r_layer        <= '0;
      r_neuron       <= '0;
      r_idx          <= '0;
      r_wptr         <= '0;
      r_init_ready   <= 1'b1;
      r_start_ready  <= 1'b0;
      r_result_valid <= 1'b0;
      r_w_ren        <= 1'b0;
      r_w_wen        <= 1'b0;
      r_w_addr       <= '0;
      r_x_ren        <= 1'b0;
      r_x_wen        <= 1'b0;
      r_x_sel        <= 1'b0;
      r_x_addr       <= '0;
      r_ps_store     <= 1'b0;
      r_x_wb         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Init has priority; a start seen in the same cycle is dropped.
          if (init_valid_i && r_init_ready) begin
            r_state       <= S_LOAD_W;
            r_init_ready  <= 1'b0;
            r_start_ready <= 1'b0;
            r_w_wen       <= 1'b1;
            r_w_addr      <= '0;
          end else if (start_valid_i && r_start_ready) begin
            r_state       <= S_READ;
            r_init_ready  <= 1'b0;
            r_start_ready <= 1'b0;
            r_layer       <= '0;
            r_neuron      <= '0;
            r_idx         <= '0;
            r_wptr        <= '0;
            r_w_ren       <= 1'b1;
            r_x_ren       <= 1'b1;
            r_w_addr      <= '0;
            r_x_addr      <= '0;
            r_x_sel       <= 1'b0;
          end
        end

        S_LOAD_W: begin
          if (r_w_addr == c_W_LAST) begin
            r_state  <= S_LOAD_X;
            r_w_wen  <= 1'b0;
            r_w_addr <= '0;
            r_x_wen  <= 1'b1;
            r_x_sel  <= 1'b0;
            r_x_addr <= '0;
          end else begin
            r_w_addr <= r_w_addr + 11'd1;
          end
        end

        S_LOAD_X: begin
          if (r_x_addr == c_IN_LAST) begin
            r_state       <= S_IDLE;
            r_init_done   <= 1'b1;
            r_x_wen       <= 1'b0;
            r_x_addr      <= '0;
            r_init_ready  <= 1'b1;
            r_start_ready <= 1'b1;
          end else begin
            r_x_addr <= r_x_addr + 8'd1;
          end
        end

        S_READ: begin
          // Weights are consumed in strictly sequential order, so a single
          // running pointer replaces the L*N_IN*N_OUT + o*N_IN + i product.
          r_wptr <= r_wptr + 11'd1;
          if (r_idx == c_IN_LAST) begin
            r_state    <= S_STORE;
            r_idx      <= '0;
            r_w_ren    <= 1'b0;
            r_x_ren    <= 1'b0;
            r_w_addr   <= '0;
            r_x_addr   <= '0;
            r_x_sel    <= 1'b0;
            r_ps_store <= 1'b1;
          end else begin
            r_idx    <= r_idx + 8'd1;
            r_w_addr <= r_wptr + 11'd1;
            r_x_addr <= r_idx + 8'd1;
          end
        end

        S_STORE: begin
          r_state    <= S_WB;
          r_ps_store <= 1'b0;
          r_x_wen    <= 1'b1;
          r_x_wb     <= 1'b1;
          r_x_sel    <= ~r_layer[0];
          r_x_addr   <= r_neuron;
        end

        S_WB: begin
          r_x_wen  <= 1'b0;
          r_x_wb   <= 1'b0;
          r_x_sel  <= 1'b0;
          r_x_addr <= '0;
          if (r_neuron == c_OUT_LAST) begin
            r_neuron <= '0;
            if (r_layer == c_LAYER_LAST) begin
              r_state        <= S_DONE;
              r_layer        <= '0;
              r_result_valid <= 1'b1;
            end else begin
              r_state  <= S_READ;
              r_layer  <= r_layer + c_LW'(1);
              r_w_ren  <= 1'b1;
              r_x_ren  <= 1'b1;
              r_w_addr <= r_wptr;
              r_x_sel  <= ~r_layer[0];
            end
          end else begin
            r_state  <= S_READ;
            r_neuron <= r_neuron + 8'd1;
            r_w_ren  <= 1'b1;
            r_x_ren  <= 1'b1;
            r_w_addr <= r_wptr;
            r_x_sel  <= r_layer[0];
          end
        end

        S_DONE: begin
          r_state        <= S_IDLE;
          r_result_valid <= 1'b0;
          r_init_ready   <= 1'b1;
          r_start_ready  <= r_init_done;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign init_ready_o        = r_init_ready;
  assign start_ready_o       = r_start_ready;
  assign result_valid_o      = r_result_valid;
  assign w_ren_o             = r_w_ren;
  assign w_wen_o             = r_w_wen;
  assign w_addr_o            = r_w_addr;
  assign x_ren_o             = r_x_ren;
  assign x_wen_o             = r_x_wen;
  assign x_sel_o             = r_x_sel;
  assign x_addr_o            = r_x_addr;
  assign partial_sum_store_o = r_ps_store;
  assign x_sram_write_back_o = r_x_wb;

endmodule
`default_nettype wire

// File: tb/tb_mlp_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_fsm
// Brief    : Directed table-driven bench for mlp_fsm plus multi-cycle runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_v = 1'b0;
  logic        start_v = 1'b0;
  logic        init_rdy, start_rdy, res_v;
  logic        w_ren, w_wen, x_ren, x_wen, x_sel, ps_store, x_wb;
  logic [10:0] w_addr;
  logic [7:0]  x_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mlp_fsm #(.N_LAYERS(2), .N_IN(32), .N_OUT(32)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .init_valid_i       (init_v),
    .init_ready_o       (init_rdy),
    .start_valid_i      (start_v),
    .start_ready_o      (start_rdy),
    .result_valid_o     (res_v),
    .w_ren_o            (w_ren),
    .w_wen_o            (w_wen),
    .w_addr_o           (w_addr),
    .x_ren_o            (x_ren),
    .x_wen_o            (x_wen),
    .x_sel_o            (x_sel),
    .x_addr_o           (x_addr),
    .partial_sum_store_o(ps_store),
    .x_sram_write_back_o(x_wb)
  );

  typedef struct {
    string       nm;
    bit          r;
    bit          iv;
    bit          sv;
    int          hold;
    int          skip;
    logic [28:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [28:0] O(bit ir, bit sr, bit rv, bit wr, bit ww,
                                    int wa, bit xr, bit xw, bit xs, int xa,
                                    bit ps, bit wb);
    logic [10:0] a11;
    logic [7:0]  a8;
    a11 = 11'(wa);
    a8  = 8'(xa);
    return {ir, sr, rv, wr, ww, a11, xr, xw, xs, a8, ps, wb};
  endfunction

  function automatic vec_t V(string nm, bit r, bit iv, bit sv, int hold,
                             int skip, logic [28:0] e);
    vec_t v;
    v.nm = nm; v.r = r; v.iv = iv; v.sv = sv;
    v.hold = hold; v.skip = skip; v.exp = e;
    return v;
  endfunction

  function automatic logic [28:0] obs();
    return {init_rdy, start_rdy, res_v, w_ren, w_wen, w_addr,
            x_ren, x_wen, x_sel, x_addr, ps_store, x_wb};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic run_vec(vec_t v);
    rst = v.r; init_v = v.iv; start_v = v.sv;
    repeat (v.hold) step();
    rst = 1'b0; init_v = 1'b0; start_v = 1'b0;
    repeat (v.skip) step();
    check(v.nm, 32'(obs()), 32'(v.exp));
  endtask

  logic [28:0] c_IDLE0, c_IDLE1;
  int          n_first;

  initial begin
    int pulses, done_k, rd_cnt, addr_err, st_cnt, wb_cnt, exp_w;

    c_IDLE0 = O(1,0,0, 0,0,0,    0,0,0,0,  0,0);
    c_IDLE1 = O(1,1,0, 0,0,0,    0,0,0,0,  0,0);

    vecs.push_back(V("reset",          1,0,0, 10,0,    c_IDLE0));
    vecs.push_back(V("start_pre_init", 0,0,1, 1,0,     c_IDLE0));
    vecs.push_back(V("start_pre_idle", 0,0,1, 1,2,     c_IDLE0));
    vecs.push_back(V("loadw_first",    0,1,0, 1,0,     O(0,0,0, 0,1,0,    0,0,0,0,  0,0)));
    vecs.push_back(V("loadw_second",   0,0,0, 0,1,     O(0,0,0, 0,1,1,    0,0,0,0,  0,0)));
    vecs.push_back(V("loadw_last",     0,0,0, 0,2046,  O(0,0,0, 0,1,2047, 0,0,0,0,  0,0)));
    vecs.push_back(V("loadx_first",    0,0,0, 0,1,     O(0,0,0, 0,0,0,    0,1,0,0,  0,0)));
    vecs.push_back(V("loadx_last",     0,0,0, 0,31,    O(0,0,0, 0,0,0,    0,1,0,31, 0,0)));
    vecs.push_back(V("init_done_idle", 0,0,0, 0,1,     c_IDLE1));
    vecs.push_back(V("read_l0n0_i0",   0,0,1, 1,0,     O(0,0,0, 1,0,0,    1,0,0,0,  0,0)));
    vecs.push_back(V("read_l0n0_i31",  0,0,0, 0,31,    O(0,0,0, 1,0,31,   1,0,0,31, 0,0)));
    vecs.push_back(V("store_l0n0",     0,0,0, 0,1,     O(0,0,0, 0,0,0,    0,0,0,0,  1,0)));
    vecs.push_back(V("wb_l0n0",        0,0,0, 0,1,     O(0,0,0, 0,0,0,    0,1,1,0,  0,1)));
    vecs.push_back(V("read_l0n1_i0",   0,0,0, 0,1,     O(0,0,0, 1,0,32,   1,0,0,0,  0,0)));
    vecs.push_back(V("read_l1n0_i0",   0,0,0, 0,1054,  O(0,0,0, 1,0,1024, 1,0,1,0,  0,0)));
    vecs.push_back(V("wb_l1n0",        0,0,0, 0,33,    O(0,0,0, 0,0,0,    0,1,0,0,  0,1)));
    vecs.push_back(V("wb_l1n31",       0,0,0, 0,1054,  O(0,0,0, 0,0,0,    0,1,0,31, 0,1)));
    vecs.push_back(V("done",           0,0,0, 0,1,     O(0,0,1, 0,0,0,    0,0,0,0,  0,0)));
    vecs.push_back(V("idle_after_done",0,0,0, 0,1,     c_IDLE1));
    n_first = vecs.size();
    vecs.push_back(V("init_beats_start",0,1,1, 1,0,    O(0,0,0, 0,1,0,    0,0,0,0,  0,0)));
    vecs.push_back(V("reload_w_last",  0,0,0, 0,2047,  O(0,0,0, 0,1,2047, 0,0,0,0,  0,0)));
    vecs.push_back(V("reload_idle",    0,0,0, 0,33,    c_IDLE1));
    vecs.push_back(V("read3_i5",       0,0,1, 1,5,     O(0,0,0, 1,0,5,    1,0,0,5,  0,0)));
    vecs.push_back(V("rst_mid_compute",1,0,0, 1,0,     c_IDLE0));
    vecs.push_back(V("start_after_rst",0,0,1, 1,1,     c_IDLE0));

    for (int i = 0; i < n_first; i++) run_vec(vecs[i]);

    // Second inference without reload: latency, pulse count and read order.
    start_v = 1'b1;
    step();
    start_v = 1'b0;
    pulses = 0; done_k = -1; rd_cnt = 0; addr_err = 0;
    st_cnt = 0; wb_cnt = 0; exp_w = 0;
    for (int k = 0; k < 2300; k++) begin
      if (w_ren) begin
        if (w_addr !== 11'(exp_w)) addr_err++;
        exp_w++;
        rd_cnt++;
      end
      if (ps_store) st_cnt++;
      if (x_wb && x_wen) wb_cnt++;
      if (res_v) begin
        pulses++;
        if (done_k < 0) done_k = k;
      end
      step();
    end
    check("run2_done_latency", 32'(done_k + 1), 32'd2177);
    check("run2_result_pulses", 32'(pulses), 32'd1);
    check("run2_read_count", 32'(rd_cnt), 32'd2048);
    check("run2_waddr_order_errs", 32'(addr_err), 32'd0);
    check("run2_store_count", 32'(st_cnt), 32'd64);
    check("run2_wb_count", 32'(wb_cnt), 32'd64);
    check("run2_idle_after", 32'(obs()), 32'(c_IDLE1));

    for (int i = n_first; i < vecs.size(); i++) run_vec(vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
